// File: rtl/warp_scheduler.sv
// Per-core warp scheduler: tracks warp lifecycle and grants the single fetch/issue
// pipeline to READY warps in round-robin order through a registered valid/ready grant.
module warp_scheduler #(
    parameter int WARPS_PER_CORE = 4,
    parameter int WARP_ID_WIDTH  = (WARPS_PER_CORE > 1) ? $clog2(WARPS_PER_CORE) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [WARP_ID_WIDTH:0]    num_warps,
    output logic                      issue_valid,
    input  logic                      issue_ready,
    output logic [WARP_ID_WIDTH-1:0]  issue_warp_id,
    input  logic [WARPS_PER_CORE-1:0] warp_resume,
    input  logic [WARPS_PER_CORE-1:0] warp_exit,
    output logic                      busy,
    output logic                      done
);
    // state | meaning
    // IDLE  | waiting for start, all warps inactive
    // RUN   | warps active, arbitrating the issue pipeline
    // DONE  | every active warp exited, held until reset
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} fsm_t;
    typedef enum logic [1:0] {W_INACTIVE, W_READY, W_BUSY, W_EXITED} warp_t;

    localparam logic [WARP_ID_WIDTH-1:0] LAST_ID = WARP_ID_WIDTH'(WARPS_PER_CORE - 1);

    fsm_t                     fsm, fsm_next;
    warp_t                    warp_state      [WARPS_PER_CORE];
    warp_t                    warp_state_next [WARPS_PER_CORE];
    logic [WARP_ID_WIDTH-1:0] rr_ptr, rr_ptr_next;
    logic                     grant_valid, grant_valid_next;
    logic [WARP_ID_WIDTH-1:0] grant_id, grant_id_next;
    logic                     pick_found;
    logic [WARP_ID_WIDTH-1:0] pick_id;
    logic [WARP_ID_WIDTH-1:0] scan_id;
    int                       scan_int;
    logic                     accept;
    logic                     any_live;

    assign accept        = grant_valid && issue_ready;
    assign issue_valid   = grant_valid;
    assign issue_warp_id = grant_id;

    // First READY warp at or after rr_ptr, wrapping around the slot count.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        scan_int   = 0;
        scan_id    = '0;
        for (int k = 0; k < WARPS_PER_CORE; k++) begin
            scan_int = int'(rr_ptr) + k;
            if (scan_int >= WARPS_PER_CORE) scan_int = scan_int - WARPS_PER_CORE;
            scan_id = WARP_ID_WIDTH'(scan_int);
            if (!pick_found && warp_state[scan_id] == W_READY) begin
                pick_found = 1'b1;
                pick_id    = scan_id;
            end
        end
    end

    always_comb begin
        fsm_next         = fsm;
        rr_ptr_next      = rr_ptr;
        grant_valid_next = grant_valid;
        grant_id_next    = grant_id;
        any_live         = 1'b0;
        for (int i = 0; i < WARPS_PER_CORE; i++) warp_state_next[i] = warp_state[i];

        case (fsm)
            S_IDLE: begin
                if (start) begin
                    if (num_warps == '0) begin
                        fsm_next = S_DONE;
                    end else begin
                        fsm_next = S_RUN;
                        for (int i = 0; i < WARPS_PER_CORE; i++)
                            warp_state_next[i] = ((WARP_ID_WIDTH+1)'(i) < num_warps) ? W_READY : W_INACTIVE;
                    end
                end
            end
            S_RUN: begin
                // The granted warp is still READY here, so a same-cycle resume falls through.
                for (int i = 0; i < WARPS_PER_CORE; i++) begin
                    if (accept && grant_id == WARP_ID_WIDTH'(i))
                        warp_state_next[i] = W_BUSY;
                    else if (warp_state[i] == W_BUSY && warp_exit[i])
                        warp_state_next[i] = W_EXITED;
                    else if (warp_state[i] == W_BUSY && warp_resume[i])
                        warp_state_next[i] = W_READY;
                    if (warp_state_next[i] == W_READY || warp_state_next[i] == W_BUSY)
                        any_live = 1'b1;
                end
                if (accept) begin
                    grant_valid_next = 1'b0;
                    rr_ptr_next      = (grant_id == LAST_ID) ? '0 : grant_id + WARP_ID_WIDTH'(1);
                end else if (!grant_valid && pick_found) begin
                    grant_valid_next = 1'b1;
                    grant_id_next    = pick_id;
                end
                if (!any_live) begin
                    fsm_next         = S_DONE;
                    grant_valid_next = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm         <= S_IDLE;
            rr_ptr      <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            for (int i = 0; i < WARPS_PER_CORE; i++) warp_state[i] <= W_INACTIVE;
        end else begin
            fsm         <= fsm_next;
            rr_ptr      <= rr_ptr_next;
            grant_valid <= grant_valid_next;
            grant_id    <= grant_id_next;
            busy        <= (fsm_next == S_RUN);
            done        <= (fsm_next == S_DONE);
            for (int i = 0; i < WARPS_PER_CORE; i++) warp_state[i] <= warp_state_next[i];
        end
    end
endmodule
